// File: rtl/xc_malu_mul_seq.sv
// ---------------------------------------------------------------------------
// xc_malu_mul_seq
//
// Sequential controller for the MALU multiply datapath. It performs a
// 32-step shift-and-add multiply. Each cycle it does one step, using a
// 33-bit add/sub built from a 32-bit adder plus a separately formed top bit.
//
// Optional feature macro: XC_MALU_MUL_CLMUL_EN
//   defined   : op_clmul / op_clmulh select a carryless (XOR) accumulate.
//   undefined : carryless path not built. clmul ops still run for 33 cycles
//               and pulse ready, but they return result = 0.
//
// Ports
//   g_clk      in   1  clock, rising edge
//   g_reset    in   1  asynchronous reset, active-high
//   valid      in   1  operation request, sampled only in IDLE
//   flush      in   1  abort; next state IDLE and ready suppressed
//   rs1        in  32  multiplicand (latched on accept)
//   rs2        in  32  multiplier (loaded into argument shift register)
//   op_mul     in   1  low half of product
//   op_mulh    in   1  high half, signed x signed
//   op_mulhu   in   1  high half, unsigned x unsigned
//   op_mulhsu  in   1  high half, signed rs1 x unsigned rs2
//   op_clmul   in   1  low half of carryless product
//   op_clmulh  in   1  high half of carryless product
//   busy       out  1  high in RUN and DONE
//   ready      out  1  one-cycle result-valid pulse (in DONE, unless flushed)
//   result     out 32  selected product half, 0 whenever ready is low
//
// Handshake: a request is taken on a rising edge where the block is IDLE,
// valid=1 and flush=0. valid is ignored at all other times. The result is
// only valid in the single cycle where ready=1. There is no back-pressure
// from the consumer.
// ---------------------------------------------------------------------------
module xc_malu_mul_seq (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        valid,
    input  logic        flush,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        op_mul,
    input  logic        op_mulh,
    input  logic        op_mulhu,
    input  logic        op_mulhsu,
    input  logic        op_clmul,
    input  logic        op_clmulh,
    output logic        busy,
    output logic        ready,
    output logic [31:0] result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Opcode bit positions inside op_q
    localparam int OP_MUL    = 0;
    localparam int OP_MULH   = 1;
    localparam int OP_MULHU  = 2;
    localparam int OP_MULHSU = 3;
    localparam int OP_CLMUL  = 4;
    localparam int OP_CLMULH = 5;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q,   cnt_d;
    logic [63:0] acc_q,   acc_d;
    logic [31:0] arg_q,   arg_d;
    logic [31:0] rs1_q,   rs1_d;
    logic [5:0]  op_q,    op_d;

    // Operand-mode decode from the latched opcode
    logic lhs_sign;
    logic rhs_sign;
    logic carryless;
    logic sel_lo;
    logic sel_hi;
    logic op_ignored;

    always_comb begin
        lhs_sign = op_q[OP_MULH] | op_q[OP_MULHSU];
        rhs_sign = op_q[OP_MULH];
`ifdef XC_MALU_MUL_CLMUL_EN
        carryless  = op_q[OP_CLMUL] | op_q[OP_CLMULH];
        sel_lo     = op_q[OP_MUL] | op_q[OP_CLMUL];
        sel_hi     = op_q[OP_MULH] | op_q[OP_MULHU] | op_q[OP_MULHSU] | op_q[OP_CLMULH];
        op_ignored = 1'b0;
`else
        // Carryless ops still run the (plain add) sequence so timing is
        // identical, but their result is forced to zero.
        carryless  = 1'b0;
        sel_lo     = op_q[OP_MUL];
        sel_hi     = op_q[OP_MULH] | op_q[OP_MULHU] | op_q[OP_MULHSU];
        op_ignored = op_q[OP_CLMUL] | op_q[OP_CLMULH];
`endif
    end

    // One shift-and-add step
    logic [32:0] add_a;
    logic [32:0] add_b;
    logic        add_sub;
    logic [31:0] rhs_lo;
    logic [31:0] sum_lo;
    logic        carry_31;
    logic        sum_hi;
    logic [32:0] step_s;

    always_comb begin
        add_a   = {lhs_sign & acc_q[63], acc_q[63:32]};
        add_b   = arg_q[0] ? {lhs_sign & rs1_q[31], rs1_q} : 33'd0;
        // A signed multiplier's MSB has negative weight: subtract on the last
        // step. arg_q[0] holds the original rs2[31] when cnt_q is 31.
        add_sub = rhs_sign & (cnt_q == 6'd31) & arg_q[0] & (rs1_q != 32'd0);
        // 32-bit unit: a + (b ^ sub) + sub gives a - b when sub is set
        rhs_lo  = add_b[31:0] ^ {32{add_sub}};
        {carry_31, sum_lo} = {1'b0, add_a[31:0]} + {1'b0, rhs_lo} + {32'd0, add_sub};
        // Bit 32 of the 33-bit result, completing the sum from the carry out
        sum_hi  = add_a[32] ^ add_b[32] ^ add_sub ^ carry_31;
        if (carryless) begin
            step_s = {1'b0, add_a[31:0] ^ add_b[31:0]};
        end else begin
            step_s = {sum_hi, sum_lo};
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        arg_d   = arg_q;
        rs1_d   = rs1_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (valid && !flush) begin
                    state_d = ST_RUN;
                    rs1_d   = rs1;
                    op_d    = {op_clmulh, op_clmul, op_mulhsu, op_mulhu, op_mulh, op_mul};
                    arg_d   = rs2;
                    acc_d   = 64'd0;
                    cnt_d   = 6'd0;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 6'd32) begin
                    state_d = ST_DONE;
                end else begin
                    acc_d = {step_s, acc_q[31:1]};
                    arg_d = {1'b0, arg_q[31:1]};
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            acc_q   <= 64'd0;
            arg_q   <= 32'd0;
            rs1_q   <= 32'd0;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            arg_q   <= arg_d;
            rs1_q   <= rs1_d;
            op_q    <= op_d;
        end
    end

    // Outputs are decoded from state so reset clears them immediately
    always_comb begin
        busy   = (state_q == ST_RUN) || (state_q == ST_DONE);
        ready  = (state_q == ST_DONE) && !flush;
        result = 32'd0;
        if (ready && !op_ignored) begin
            if (sel_lo) begin
                result = acc_q[31:0];
            end else if (sel_hi) begin
                result = acc_q[63:32];
            end
        end
    end

endmodule

// File: tb/tb_xc_malu_mul_seq.sv
module tb_xc_malu_mul_seq;

  logic        g_clk;
  logic        g_reset;
  logic        valid;
  logic        flush;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        op_mul;
  logic        op_mulh;
  logic        op_mulhu;
  logic        op_mulhsu;
  logic        op_clmul;
  logic        op_clmulh;
  logic        busy;
  logic        ready;
  logic [31:0] result;

  xc_malu_mul_seq dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .valid     (valid),
    .flush     (flush),
    .rs1       (rs1),
    .rs2       (rs2),
    .op_mul    (op_mul),
    .op_mulh   (op_mulh),
    .op_mulhu  (op_mulhu),
    .op_mulhsu (op_mulhsu),
    .op_clmul  (op_clmul),
    .op_clmulh (op_clmulh),
    .busy      (busy),
    .ready     (ready),
    .result    (result)
  );

  // ---------------- clock / reset ----------------
  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  localparam int OP_MUL    = 0;
  localparam int OP_MULH   = 1;
  localparam int OP_MULHU  = 2;
  localparam int OP_MULHSU = 3;
  localparam int OP_CLMUL  = 4;
  localparam int OP_CLMULH = 5;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_op(input int idx);
    logic [5:0] v;
    v = 6'b000001 << idx;
    {op_clmulh, op_clmul, op_mulhsu, op_mulhu, op_mulh, op_mul} = v;
  endtask

  // Issue one op, optionally keep valid high with scrambled operands while
  // busy, then wait (bounded) for the ready pulse and check everything.
  task automatic run_op(input string tag, input int op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit hold);
    int          n;
    bit          busy_ok;
    bit          seen;
    logic [31:0] e;
    exp_q.push_back(exp);
    valid = 1'b1;
    rs1   = a;
    rs2   = b;
    set_op(op);
    @(posedge g_clk); #1;
    valid = hold;
    rs1   = $urandom;
    rs2   = $urandom;
    n       = 0;
    busy_ok = 1'b1;
    seen    = 1'b0;
    while (n < 40 && !seen) begin
      if (busy !== 1'b1 || result !== 32'd0) busy_ok = 1'b0;
      @(posedge g_clk); #1;
      n++;
      if (ready === 1'b1) seen = 1'b1;
    end
    valid = 1'b0;
    check_eq({tag, " latency"}, n, 33);
    check_eq({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    e = exp_q.pop_front();
    check_eq({tag, " result"}, result, e);
    @(posedge g_clk); #1;
    check_eq({tag, " idle"}, {30'd0, busy, ready}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    g_reset = 1'b1;
    valid   = 1'b0;
    flush   = 1'b0;
    rs1     = 32'd0;
    rs2     = 32'd0;
    set_op(OP_MUL);
    repeat (2) @(posedge g_clk);
    #1;
    check_eq("reset outs", {30'd0, busy, ready}, 32'd0);
    check_eq("reset result", result, 32'd0);
    @(negedge g_clk);
    g_reset = 1'b0;
    @(posedge g_clk); #1;
    check_eq("post reset idle", {30'd0, busy, ready}, 32'd0);

    // basic products
    run_op("mul 7x6",          OP_MUL,    32'd7,          32'd6,          32'h0000002A, 1'b0);
    run_op("mulh min*min",     OP_MULH,   32'h80000000,   32'h80000000,   32'h40000000, 1'b0);
    run_op("mulh -1*2",        OP_MULH,   32'hFFFFFFFF,   32'h00000002,   32'hFFFFFFFF, 1'b0);
    run_op("mulhu max*max",    OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 1'b1);
    run_op("mul max*max",      OP_MUL,    32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 1'b0);
    run_op("mulhsu -1*max",    OP_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF, 1'b0);
    run_op("mulhsu 3*2^31",    OP_MULHSU, 32'h00000003,   32'h80000000,   32'h00000001, 1'b0);
    run_op("mulh 0*min",       OP_MULH,   32'h00000000,   32'h80000000,   32'h00000000, 1'b0);
    run_op("mulh -3*-5",       OP_MULH,   32'hFFFFFFFD,   32'hFFFFFFFB,   32'h00000000, 1'b0);
    run_op("mul -3*-5",        OP_MUL,    32'hFFFFFFFD,   32'hFFFFFFFB,   32'h0000000F, 1'b1);
    run_op("mulh -1*-1",       OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 1'b0);
    run_op("mulhu 2^31*4",     OP_MULHU,  32'h80000000,   32'h00000004,   32'h00000002, 1'b0);

`ifdef XC_MALU_MUL_CLMUL_EN
    run_op("clmul 3x3",        OP_CLMUL,  32'h00000003,   32'h00000003,   32'h00000005, 1'b0);
    run_op("clmulh min*min",   OP_CLMULH, 32'h80000000,   32'h80000000,   32'h40000000, 1'b0);
    run_op("clmul ff x 3",     OP_CLMUL,  32'h000000FF,   32'h00000003,   32'h00000101, 1'b0);
`else
    run_op("clmul off",        OP_CLMUL,  32'h00000003,   32'h00000003,   32'h00000000, 1'b0);
    run_op("clmulh off",       OP_CLMULH, 32'h80000000,   32'h80000000,   32'h00000000, 1'b0);
`endif

    // flush in IDLE overrides valid
    valid = 1'b1;
    flush = 1'b1;
    rs1   = 32'd9;
    rs2   = 32'd9;
    set_op(OP_MUL);
    @(posedge g_clk); #1;
    check_eq("flush idle busy", {31'd0, busy}, 32'd0);
    valid = 1'b0;
    flush = 1'b0;

    // flush at counter 10: IDLE next cycle, no ready afterwards
    valid = 1'b1;
    rs1   = 32'd7;
    rs2   = 32'd6;
    set_op(OP_MUL);
    @(posedge g_clk); #1;
    valid = 1'b0;
    repeat (10) @(posedge g_clk);
    #1;
    check_eq("pre flush busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge g_clk); #1;
    flush = 1'b0;
    check_eq("flush run idle", {30'd0, busy, ready}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge g_clk); #1;
      if (ready === 1'b1) pulses++;
    end
    check_eq("flush no ready", pulses, 32'd0);
    run_op("mul 3x5 after flush", OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0);

    // flush during DONE suppresses the ready pulse
    valid = 1'b1;
    rs1   = 32'd7;
    rs2   = 32'd6;
    set_op(OP_MUL);
    @(posedge g_clk); #1;
    valid = 1'b0;
    repeat (33) @(posedge g_clk);
    #1;
    check_eq("done ready", {31'd0, ready}, 32'd1);
    flush = 1'b1;
    #1;
    check_eq("flush done ready", {31'd0, ready}, 32'd0);
    check_eq("flush done result", result, 32'd0);
    @(posedge g_clk); #1;
    flush = 1'b0;
    check_eq("flush done idle", {31'd0, busy}, 32'd0);

    // async reset mid-RUN clears outputs without a clock edge
    valid = 1'b1;
    rs1   = 32'hFFFFFFFF;
    rs2   = 32'hFFFFFFFF;
    set_op(OP_MULHU);
    @(posedge g_clk); #1;
    valid = 1'b0;
    repeat (5) @(posedge g_clk);
    #1;
    check_eq("mid run busy", {31'd0, busy}, 32'd1);
    #2;
    g_reset = 1'b1;
    #1;
    check_eq("async reset outs", {30'd0, busy, ready}, 32'd0);
    check_eq("async reset result", result, 32'd0);
    @(negedge g_clk);
    g_reset = 1'b0;
    @(posedge g_clk); #1;
    run_op("mul 7x6 after reset", OP_MUL, 32'd7, 32'd6, 32'h0000002A, 1'b0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xc_malu_mul_seq.md
Name: xc_malu_mul_seq

Overview:
Sequential controller for the MALU multiply datapath.
- Owns the counter, the 64-bit accumulator, the multiplier-argument shift register, latched operands and the 32-bit add/sub unit.
- Performs one shift-and-add step per cycle for 32 cycles.
- Sits between the issue stage, which supplies operands and opcode, and the writeback mux, which consumes the result on the ready pulse.

Parameters:
None (all widths fixed at 32-bit operands, 64-bit product).

Ports:
g_clk       input   1   clock; all state changes on its rising edge
g_reset     input   1   asynchronous reset, active-high
valid       input   1   operation request; operands and opcode are sampled in IDLE
flush       input   1   abort the current operation and return to IDLE
rs1         input   32  multiplicand
rs2         input   32  multiplier
op_mul      input   1   low 32 bits of the product
op_mulh     input   1   high 32 bits, signed x signed
op_mulhu    input   1   high 32 bits, unsigned x unsigned
op_mulhsu   input   1   high 32 bits, signed rs1 x unsigned rs2
op_clmul    input   1   low 32 bits of the carryless product (only with macro)
op_clmulh   input   1   high 32 bits of the carryless product (only with macro)
busy        output  1   high in RUN and DONE
ready       output  1   single-cycle result-valid pulse
result      output  32  selected product half; 0 when ready is low

Behaviour:
- States: IDLE, RUN, DONE. Exactly one op_* is high with valid; any other combination is undefined.
- Reset (async) sets:
  - state IDLE, counter 0, accumulator 0, argument 0, latched rs1 and opcode 0;
  - outputs busy=0, ready=0, result=0.
- IDLE, valid && !flush:
  - latch rs1 and opcode; set argument=rs2, accumulator=0, counter=0; go to RUN.
  - lhs_sign = mulh|mulhsu; rhs_sign = mulh; carryless = clmul|clmulh.
- RUN step, with counter c in 0..31 (one step per cycle):
  - a = {lhs_sign & acc[63], acc[63:32]}.
  - b = argument[0] ? {lhs_sign & rs1[31], rs1} : 0.
  - sub = rhs_sign & (c==31) & rs2[31] & (rs1!=0).
  - Non-carryless: s = sub ? a - b : a + b, computed as 33 bits. The 32-bit unit takes lhs/rhs/sub, and bit 32 is formed from a[32], b[32], sub and the carry out of bit 31.
  - Carryless: s = {1'b0, a[31:0] ^ b[31:0]}.
  - acc <= {s, acc[31:1]}; argument <= {1'b0, argument[31:1]}; c <= c+1.
- When c reaches 32, go to DONE. Enter DONE exactly 33 cycles after the accept edge.
- DONE:
  - ready=1 for one cycle.
  - result = acc[31:0] for mul/clmul; acc[63:32] otherwise.
  - Next state is IDLE unconditionally. valid is not sampled in DONE. Upstream deasserts valid or presents the next op, which is accepted from IDLE the following cycle.
- flush:
  - In any state, next state is IDLE and ready is forced 0 in that cycle.
  - In IDLE, flush overrides valid: nothing is accepted.
- valid while busy: ignored. Operand changes during RUN have no effect because the operands are latched.
- Reset mid-operation: immediate IDLE and all outputs 0, regardless of state.
- Counter width is 6 bits. It never exceeds 32 and does not wrap.

Optional Feature:
Macro XC_MALU_MUL_CLMUL_EN.
- Defined: op_clmul and op_clmulh are honoured and select the carryless (XOR) accumulate described above.
- Undefined: the carryless path is not built. The op_clmul and op_clmulh ports remain but are ignored. An op with only op_clmul or op_clmulh set is still accepted and completes in 33 cycles with ready pulsed and result=0.

Test Plan:
1. mul rs1=7, rs2=6 -> ready exactly 33 cycles after accept; result=0x0000002A; busy high for 33 cycles.
2. mulh rs1=0x80000000, rs2=0x80000000 -> result=0x40000000. Also mulh 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
3. mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; mul with the same operands -> 0x00000001.
4. mulhsu rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF; mulhsu rs1=0x00000003, rs2=0x80000000 -> 0x00000001.
5. Reset and flush mid-operation:
   - flush at counter 10 -> IDLE next cycle, no ready pulse. A following mul 3 x 5 -> 15 after 33 cycles.
   - g_reset asserted mid-RUN -> all outputs 0 immediately.
6. With XC_MALU_MUL_CLMUL_EN: clmul 0x3 x 0x3 -> 0x00000005; clmulh 0x80000000 x 0x80000000 -> 0x40000000.
   Without the macro: clmul -> ready after 33 cycles, result=0.
